// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner.
// Holds the button index names and the per-button debounce state encoding.
package button_conditioner_pkg;

    localparam int unsigned NUM_BTN   = 4;
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } deb_state_e;

endpackage

// File: rtl/button_conditioner_debounce_fsm.sv
// One button: synchronizer chain, debounce FSM and qualification counter.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   btn_raw      raw asynchronous button input
//   btn_level    debounced level (1 while accepted as held)
//   btn_press    one-cycle pulse on an accepted press
//   btn_release  one-cycle pulse on an accepted release
module debounce_fsm
    import button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 2_500_000,
    parameter int unsigned CNT_W           = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    deb_state_e             state_r, state_nxt_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic                   level_r, level_nxt_s;
    logic                   press_r, press_nxt_s;
    logic                   rel_r, rel_nxt_s;

    // Synchronizer chain; the last stage is the only value the FSM looks at.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // FSM, counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            rel_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            press_r <= press_nxt_s;
            rel_r   <= rel_nxt_s;
        end
    end

    // Next-state logic. The counter stops at CNT_LAST because reaching it
    // always leaves the wait state, so it can never wrap.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        press_nxt_s = 1'b0;
        rel_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync_s) begin
                    state_nxt_s = PRESS_WAIT;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!sync_s) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = PRESSED;
                    level_nxt_s = 1'b1;
                    press_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync_s) begin
                    state_nxt_s = REL_WAIT;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            REL_WAIT: begin
                // A bounce back high returns silently; level was never dropped.
                if (sync_s) begin
                    state_nxt_s = PRESSED;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE;
                    level_nxt_s = 1'b0;
                    rel_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
                level_nxt_s = 1'b0;
            end
        endcase
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = rel_r;

endmodule

// File: rtl/button_conditioner.sv
// Input stage for the game controller: four debounced push-buttons, a
// game tick divider and sticky press events held until the next tick.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   btn_raw      raw buttons (0=up, 1=down, 2=left, 3=right)
//   btn_level    debounced levels
//   btn_press    one-cycle press pulses
//   btn_release  one-cycle release pulses
//   press_evt    sticky press flags, cleared after each game_tick
//   game_tick    one-cycle pulse every TICK_DIV clocks
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 2_500_000,
    parameter int unsigned CNT_W           = 22,
    parameter int unsigned TICK_DIV        = 500_000,
    parameter int unsigned TICK_W          = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   btn_raw,
    output logic [3:0]   btn_level,
    output logic [3:0]   btn_press,
    output logic [3:0]   btn_release,
    output logic [3:0]   press_evt,
    output logic         game_tick
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tcnt_r;
    logic              tick_r;
    logic [3:0]        evt_r;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_fsm #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk         (clk),
            .rst         (rst),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

    // Tick divider: pulse on the edge where the counter wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_r <= '0;
            tick_r <= 1'b0;
        end else if (tcnt_r == TICK_LAST) begin
            tcnt_r <= '0;
            tick_r <= 1'b1;
        end else begin
            tcnt_r <= tcnt_r + TICK_W'(1);
            tick_r <= 1'b0;
        end
    end

    // Sticky events: a press coinciding with the tick cycle wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_r <= 4'b0000;
        end else if (tick_r) begin
            evt_r <= btn_press;
        end else begin
            evt_r <= evt_r | btn_press;
        end
    end

    assign game_tick = tick_r;
    assign press_evt = evt_r;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int TDIV = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] btn_level, btn_press, btn_release, press_evt;
    logic       game_tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a new level is accepted after DEB+1 consecutive
    // synchronized samples that disagree with the current level; the
    // synchronized sample is the raw input seen SYNC edges earlier.
    logic [3:0] m_hist [SYNC];
    int         m_run  [4];
    logic [3:0] m_level, m_press, m_rel, m_evt;
    logic       m_tick;
    int         m_edges;

    button_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(4),
        .TICK_DIV(TDIV), .TICK_W(5)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .press_evt(press_evt), .game_tick(game_tick)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_hist[i] = 4'b0000;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_level = 4'b0000; m_press = 4'b0000; m_rel = 4'b0000;
        m_evt = 4'b0000; m_tick = 1'b0; m_edges = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] s, np, nr, nevt;
        s = m_hist[SYNC-1];
        for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = raw;
        nevt = m_press | (m_tick ? 4'b0000 : m_evt);
        np = 4'b0000; nr = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            if (s[b] !== m_level[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB + 1) begin
                    m_level[b] = s[b];
                    if (s[b]) np[b] = 1'b1; else nr[b] = 1'b1;
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_edges++;
        m_tick  = (m_edges % TDIV) == 0;
        m_press = np; m_rel = nr; m_evt = nevt;
    endtask

    // Advance one clock; outputs are then stable 1 time unit after the edge.
    task automatic step();
        logic [3:0] raw_at_edge;
        raw_at_edge = btn_raw;
        @(posedge clk);
        #1;
        if (rst) model_edge(raw_at_edge);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        btn_raw = 4'b1111;
        apply_reset();
        step();
        step();
        n_tests++;
        if ({btn_level, btn_press, btn_release, press_evt, game_tick} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h",
                     {btn_level, btn_press, btn_release, press_evt, game_tick}, 17'h0);
        end
        btn_raw = 4'b0000;
        rst = 1'b1;
    endtask

    task automatic test_clean_press();
        apply_reset(); rst = 1'b1;
        btn_raw = 4'b0001;
        for (int k = 1; k <= 30; k++) begin
            step();
            n_tests++;
            if ({btn_level, btn_press, btn_release, press_evt, game_tick} !==
                {m_level, m_press, m_rel, m_evt, m_tick}) begin
                n_fail++;
                $display("FAIL clean_press cyc %0d: got %h expected %h", k,
                         {btn_level, btn_press, btn_release, press_evt, game_tick},
                         {m_level, m_press, m_rel, m_evt, m_tick});
            end
            if (k == 10 || k == 11 || k == 12) begin
                n_tests++;
                if (btn_press !== ((k == 11) ? 4'b0001 : 4'b0000) ||
                    btn_level !== ((k >= 11) ? 4'b0001 : 4'b0000)) begin
                    n_fail++;
                    $display("FAIL clean_press_latency edge %0d: press %b level %b", k, btn_press, btn_level);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int presses;
        presses = 0;
        apply_reset(); rst = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            // toggles every 3 cycles for 15 cycles, last rising after edge 12
            if (k <= 15) btn_raw = (((k - 1) / 3) % 2 == 0) ? 4'b0010 : 4'b0000;
            else btn_raw = 4'b0010;
            step();
            if (btn_press[1]) presses++;
            n_tests++;
            if ({btn_level, btn_press, btn_release, press_evt, game_tick} !==
                {m_level, m_press, m_rel, m_evt, m_tick}) begin
                n_fail++;
                $display("FAIL bounce cyc %0d: got %h expected %h", k,
                         {btn_level, btn_press, btn_release, press_evt, game_tick},
                         {m_level, m_press, m_rel, m_evt, m_tick});
            end
            if (k == 23) begin
                n_tests++;
                if (btn_press[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bounce_press_edge: got %b expected 1", btn_press[1]);
                end
            end
        end
        n_tests++;
        if (presses != 1) begin
            n_fail++;
            $display("FAIL bounce_press_count: got %0d expected 1", presses);
        end
    endtask

    task automatic test_release_glitch();
        int rels;
        rels = 0;
        apply_reset(); rst = 1'b1;
        btn_raw = 4'b0100;
        for (int k = 1; k <= 56; k++) begin
            if (k == 16) btn_raw = 4'b0000;
            if (k == 20) btn_raw = 4'b0100;
            if (k == 30) btn_raw = 4'b0000;
            step();
            if (btn_release[2]) rels++;
            n_tests++;
            if ({btn_level, btn_press, btn_release, press_evt, game_tick} !==
                {m_level, m_press, m_rel, m_evt, m_tick}) begin
                n_fail++;
                $display("FAIL release_glitch cyc %0d: got %h expected %h", k,
                         {btn_level, btn_press, btn_release, press_evt, game_tick},
                         {m_level, m_press, m_rel, m_evt, m_tick});
            end
            if (k == 29) begin
                n_tests++;
                if (btn_level[2] !== 1'b1 || rels != 0) begin
                    n_fail++;
                    $display("FAIL glitch_held: level %b releases %0d expected 1 and 0", btn_level[2], rels);
                end
            end
        end
        n_tests++;
        if (rels != 1 || btn_level[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL release_count: releases %0d level %b expected 1 and 0", rels, btn_level[2]);
        end
    endtask

    task automatic test_events();
        apply_reset(); rst = 1'b1;
        btn_raw = 4'b0001;
        for (int k = 1; k <= 45; k++) begin
            if (k == 10) btn_raw = 4'b0011;  // button 1 press lands on tick edge 20
            step();
            n_tests++;
            if ({btn_level, btn_press, btn_release, press_evt, game_tick} !==
                {m_level, m_press, m_rel, m_evt, m_tick}) begin
                n_fail++;
                $display("FAIL events cyc %0d: got %h expected %h", k,
                         {btn_level, btn_press, btn_release, press_evt, game_tick},
                         {m_level, m_press, m_rel, m_evt, m_tick});
            end
            if (k == 20 || k == 21 || k == 41) begin
                n_tests++;
                if ((k == 20 && (press_evt !== 4'b0001 || game_tick !== 1'b1 || btn_press !== 4'b0010)) ||
                    (k == 21 && press_evt !== 4'b0010) ||
                    (k == 41 && press_evt !== 4'b0000)) begin
                    n_fail++;
                    $display("FAIL events_sticky edge %0d: evt %b tick %b press %b", k, press_evt, game_tick, btn_press);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        apply_reset(); rst = 1'b1;
        btn_raw = 4'b0001;
        for (int k = 1; k <= 14; k++) step();
        btn_raw = 4'b0101;
        for (int k = 1; k <= 6; k++) step();
        #2;
        apply_reset();
        n_tests++;
        if ({btn_level, btn_press, btn_release, press_evt, game_tick} !== 17'h0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got %h expected %h",
                     {btn_level, btn_press, btn_release, press_evt, game_tick}, 17'h0);
        end
        rst = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            n_tests++;
            if ({btn_level, btn_press, btn_release, press_evt, game_tick} !==
                {m_level, m_press, m_rel, m_evt, m_tick}) begin
                n_fail++;
                $display("FAIL mid_reset cyc %0d: got %h expected %h", k,
                         {btn_level, btn_press, btn_release, press_evt, game_tick},
                         {m_level, m_press, m_rel, m_evt, m_tick});
            end
            if (k == 10 || k == 11) begin
                n_tests++;
                if (btn_press !== ((k == 11) ? 4'b0101 : 4'b0000)) begin
                    n_fail++;
                    $display("FAIL mid_reset_latency edge %0d: got %b", k, btn_press);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int rels [4];
        for (int b = 0; b < 4; b++) rels[b] = 0;
        apply_reset(); rst = 1'b1;
        btn_raw = 4'b1111;
        for (int k = 1; k <= 60; k++) begin
            if (k >= 15 && k <= 24 && (k - 15) % 3 == 0) btn_raw[(k - 15) / 3] = 1'b0;
            step();
            for (int b = 0; b < 4; b++) if (btn_release[b]) rels[b]++;
            n_tests++;
            if ({btn_level, btn_press, btn_release, press_evt, game_tick} !==
                {m_level, m_press, m_rel, m_evt, m_tick}) begin
                n_fail++;
                $display("FAIL simultaneous cyc %0d: got %h expected %h", k,
                         {btn_level, btn_press, btn_release, press_evt, game_tick},
                         {m_level, m_press, m_rel, m_evt, m_tick});
            end
            if (k == 11) begin
                n_tests++;
                if (btn_press !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL simultaneous_press: got %b expected 1111", btn_press);
                end
            end
        end
        for (int b = 0; b < 4; b++) begin
            n_tests++;
            if (rels[b] != 1) begin
                n_fail++;
                $display("FAIL staggered_release btn %0d: got %0d pulses expected 1", b, rels[b]);
            end
        end
    endtask

    task automatic test_random();
        int flip_odds;
        apply_reset(); rst = 1'b1;
        btn_raw = 4'b0000;
        flip_odds = 5;
        for (int k = 1; k <= 1500; k++) begin
            if (k % 100 == 0) flip_odds = $urandom_range(2, 30);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, flip_odds) == 0) btn_raw[b] = ~btn_raw[b];
            if ($urandom_range(0, 400) == 0) begin
                #2;
                apply_reset();
                rst = 1'b1;
            end
            step();
            n_tests++;
            if ({btn_level, btn_press, btn_release, press_evt, game_tick} !==
                {m_level, m_press, m_rel, m_evt, m_tick}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h expected %h", k,
                         {btn_level, btn_press, btn_release, press_evt, game_tick},
                         {m_level, m_press, m_rel, m_evt, m_tick});
            end
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_events();
        test_reset_mid_op();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
